// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline-control types and constants
package riscv_pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} ctrl_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int CTRL_CNT_W = 16;
endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: clearable saturating up-counter used by the stall and wait watchdogs
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] cnt_d, cnt_q;
  // clear wins over increment; holds at all-ones instead of wrapping
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush/freeze sequencing for the 5-stage pipe; STALL_PERF_EN adds perf counters
module pipeline_stall_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int FLUSH_EXTRA = 1,
  parameter int MAX_STALL   = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_req,
  input  logic        flush_req,
  input  logic        dmem_wait,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_we,
  output logic        id_ex_flush,
  output logic        ex_mem_we,
  output logic        mem_wb_flush,
  output logic [1:0]  ctrl_state,
  output logic        hazard_err,
  output logic        mem_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_wait
`endif
);
  localparam logic [1:0]            FLUSH_EXTRA_C = 2'(FLUSH_EXTRA);
  localparam logic [CTRL_CNT_W-1:0] MAX_STALL_C   = CTRL_CNT_W'(MAX_STALL);
  localparam logic [CTRL_CNT_W-1:0] MEM_TIMEOUT_C = CTRL_CNT_W'(MEM_TIMEOUT);
  ctrl_state_t state_d, state_q;
  logic [1:0] flush_cnt_d, flush_cnt_q;
  logic hazard_err_d, hazard_err_q, mem_timeout_d, mem_timeout_q, stall_hit;
  logic [CTRL_CNT_W-1:0] stall_cnt, wait_cnt;
  sat_counter #(.WIDTH(CTRL_CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(!stall_hit), .inc(stall_hit), .q(stall_cnt)
  );
  sat_counter #(.WIDTH(CTRL_CNT_W)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .clr(!dmem_wait), .inc(dmem_wait), .q(wait_cnt)
  );
  // prioritised decode: dmem_wait > flush_req > flush window > stall_req > run
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    hazard_err_d  = hazard_err_q;
    mem_timeout_d = mem_timeout_q;
    stall_hit     = 1'b0;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;
    if (dmem_wait) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
      mem_wb_flush  = 1'b1;
      state_d       = (state_q == FLUSH) ? FLUSH : MEM_WAIT;
      mem_timeout_d = mem_timeout_q | (wait_cnt == MEM_TIMEOUT_C);
    end else if (flush_req) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_cnt_d = FLUSH_EXTRA_C;
      state_d     = (FLUSH_EXTRA == 0) ? RUN : FLUSH;
    end else if (state_q == FLUSH) begin
      if_id_flush = 1'b1;
      flush_cnt_d = (flush_cnt_q > 2'd1) ? flush_cnt_q - 2'd1 : 2'd0;
      state_d     = (flush_cnt_q > 2'd1) ? FLUSH : RUN;
    end else begin
      state_d = RUN;
      if (stall_req) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_flush  = 1'b1;
        stall_hit    = 1'b1;
        hazard_err_d = hazard_err_q | (stall_cnt == MAX_STALL_C);
      end
    end
    if (!rst_n) begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
      {if_id_flush, id_ex_flush, mem_wb_flush} = 3'b000;
      stall_hit = 1'b0;
    end
  end
  // state, flush window count and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flush_cnt_q   <= 2'd0;
      hazard_err_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      hazard_err_q  <= hazard_err_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
  assign ctrl_state  = state_q;
  assign hazard_err  = hazard_err_q;
  assign mem_timeout = mem_timeout_q;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_d, perf_stall_q, perf_flush_d, perf_flush_q, perf_wait_d, perf_wait_q;
  // wrapping event counters for stall, IF/ID flush and memory wait cycles
  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_hit};
    perf_flush_d = perf_flush_q + {31'd0, if_id_flush};
    perf_wait_d  = perf_wait_q + {31'd0, dmem_wait};
  end
  // perf counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_wait_q  <= perf_wait_d;
    end
  end
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
  assign perf_wait  = perf_wait_q;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, stall_req = 1'b0, flush_req = 1'b0, dmem_wait = 1'b0;
  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush;
  logic [1:0] ctrl_state;
  logic hazard_err, mem_timeout;
  logic [6:0] outs;
  int checks = 0, failures = 0;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_wait;
`endif
  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush}
  localparam logic [6:0] O_RST = 7'b0000000, O_RUN = 7'b1101010, O_STALL = 7'b0001110,
                         O_FREQ = 7'b1111110, O_FWIN = 7'b1111010, O_WAIT = 7'b0000001;
  assign outs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush};
  always #5 clk = ~clk;
  pipeline_stall_ctrl #(.FLUSH_EXTRA(1), .MAX_STALL(2), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req), .dmem_wait(dmem_wait),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
    .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we), .mem_wb_flush(mem_wb_flush),
    .ctrl_state(ctrl_state), .hazard_err(hazard_err), .mem_timeout(mem_timeout)
`ifdef STALL_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_wait(perf_wait)
`endif
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  // advance one clock, drive the new inputs, then settle to mid-cycle for sampling
  task automatic cyc(input logic r, input logic s, input logic f, input logic w);
    @(posedge clk);
    #1;
    rst_n = r; stall_req = s; flush_req = f; dmem_wait = w;
    @(negedge clk);
  endtask
  initial begin
    cyc(0, 0, 0, 0);
    check("rst_outs", 32'(outs), 32'(O_RST));
    cyc(0, 1, 1, 1);
    check("rst_forced", 32'(outs), 32'(O_RST));
    cyc(1, 0, 0, 0);
    check("idle_outs", 32'(outs), 32'(O_RUN));
    check("idle_state", 32'(ctrl_state), 0);
    check("idle_errs", 32'({hazard_err, mem_timeout}), 0);
    cyc(1, 1, 0, 0);
    check("stall1_outs", 32'(outs), 32'(O_STALL));
    cyc(1, 0, 0, 0);
    check("stall1_after", 32'(outs), 32'(O_RUN));
    check("stall1_herr", 32'(hazard_err), 0);
    cyc(1, 0, 1, 0);
    check("flush_c0", 32'(outs), 32'(O_FREQ));
    cyc(1, 0, 0, 0);
    check("flush_c1", 32'(outs), 32'(O_FWIN));
    check("flush_c1_state", 32'(ctrl_state), 1);
    cyc(1, 0, 0, 0);
    check("flush_c2", 32'(outs), 32'(O_RUN));
    check("flush_c2_state", 32'(ctrl_state), 0);
    cyc(1, 0, 1, 0);
    check("fw_req", 32'(outs), 32'(O_FREQ));
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 1);
      check($sformatf("fw_wait%0d", i), 32'(outs), 32'(O_WAIT));
      check($sformatf("fw_wait%0d_state", i), 32'(ctrl_state), 1);
    end
    cyc(1, 0, 0, 0);
    check("fw_win", 32'(outs), 32'(O_FWIN));
    cyc(1, 0, 0, 0);
    check("fw_run", 32'(outs), 32'(O_RUN));
    check("fw_run_state", 32'(ctrl_state), 0);
    cyc(1, 1, 1, 0);
    check("fs_req", 32'(outs), 32'(O_FREQ));
    cyc(1, 1, 0, 0);
    check("fs_win_ignores_stall", 32'(outs), 32'(O_FWIN));
    cyc(1, 0, 0, 0);
    check("fs_run", 32'(outs), 32'(O_RUN));
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0);
      check($sformatf("stall3_c%0d", i), 32'(outs), 32'(O_STALL));
      check($sformatf("stall3_c%0d_herr", i), 32'(hazard_err), 0);
    end
    cyc(1, 0, 0, 0);
    check("stall3_herr", 32'(hazard_err), 1);
    cyc(1, 0, 0, 0);
    check("stall3_sticky", 32'(hazard_err), 1);
    for (int i = 0; i < 256; i++) cyc(1, 0, 0, 1);
    check("wait256_outs", 32'(outs), 32'(O_WAIT));
    check("wait256_state", 32'(ctrl_state), 2);
    check("wait256_no_to_yet", 32'(mem_timeout), 0);
    cyc(1, 0, 0, 0);
    check("wait_to", 32'(mem_timeout), 1);
    check("wait_end_outs", 32'(outs), 32'(O_RUN));
    cyc(1, 0, 0, 0);
    check("wait_end_state", 32'(ctrl_state), 0);
    check("wait_to_sticky", 32'(mem_timeout), 1);
    cyc(0, 0, 0, 0);
    check("rst2_outs", 32'(outs), 32'(O_RST));
    cyc(1, 0, 0, 0);
    check("rst2_errs", 32'({hazard_err, mem_timeout}), 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    check("rst_midflush_outs", 32'(outs), 32'(O_RST));
    cyc(1, 0, 0, 0);
    check("rst_midflush_state", 32'(ctrl_state), 0);
    check("rst_midflush_run", 32'(outs), 32'(O_RUN));
`ifdef STALL_PERF_EN
    cyc(0, 0, 0, 0);
    check("perf_rst", 32'(perf_stall | perf_flush | perf_wait), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 1, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
    end
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("perf_stall", perf_stall, 5);
    check("perf_flush", perf_flush, 4);
    check("perf_wait", perf_wait, 10);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
